// File: rtl/sprite_bus_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_bus_reader_pkg
// Description : Shared sprite memory definitions. Holds the reader FSM state
//               encoding, the legal READ_LAT range and the width of the
//               read-latency wait counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_bus_reader_pkg;

    localparam int unsigned c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_ARB   = 3'd1;
    localparam state_t c_ST_TURN  = 3'd2;
    localparam state_t c_ST_ISSUE = 3'd3;
    localparam state_t c_ST_WAIT  = 3'd4;
    localparam state_t c_ST_HOLD  = 3'd5;

    // Memory read latency, in cycles from mem_oe rise to valid bus data.
    localparam int unsigned c_READ_LAT_MIN = 1;
    localparam int unsigned c_READ_LAT_MAX = 7;

    // Wide enough to hold READ_LAT_MAX-1.
    localparam int unsigned c_WAIT_CTR_W = 3;

    function automatic logic read_lat_legal(input int unsigned lat);
        return (lat >= c_READ_LAT_MIN) && (lat <= c_READ_LAT_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_bus_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : sprite_bus_wait_ctr
// Description : Loadable down-counter with a zero flag. Counts the memory
//               read latency while the reader keeps mem_oe asserted.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_load        - load i_load_val (has priority over i_dec)
//               i_load_val    - value to load
//               i_dec         - decrement by one, saturating at zero
//               o_zero        - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_bus_wait_ctr
    import sprite_bus_reader_pkg::*;
#(
    parameter int unsigned WIDTH = c_WAIT_CTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sprite_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : sprite_bus_reader
// Description : Burst reader for sprite memory on a shared tristate data
//               bus. Arbitrates for the bus, inserts one turnaround cycle
//               after every grant, enables the memory for READ_LAT cycles
//               per word, captures the word and hands it out on a
//               valid/ready port.
// Ports       : clock, reset              - clock, async active-high reset
//               req_valid/req_ready       - burst request handshake
//               req_addr, req_len         - first word address, word count
//               bus_req, bus_gnt          - shared bus arbitration
//               mem_addr, mem_oe          - sprite memory address / enable
//               mem_data                  - sampled shared bus value
//               rd_valid/rd_ready         - read data handshake
//               rd_data, rd_last          - captured word, final-word flag
//               busy                      - not idle
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_bus_reader
    import sprite_bus_reader_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned LEN_W    = 6,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy
);

    generate
        if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
            $error("sprite_bus_reader: READ_LAT out of range 1..7");
        end
    endgenerate

    localparam logic [c_WAIT_CTR_W-1:0] c_LAT_LOAD = c_WAIT_CTR_W'(READ_LAT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_data;

    logic w_ctr_load;
    logic w_ctr_dec;
    logic w_ctr_zero;
    logic w_last_word;
    logic w_rd_fire;

    assign w_last_word = (r_len == LEN_W'(1));
    assign w_rd_fire   = (r_state == c_ST_HOLD) && rd_ready;

    // The counter is loaded on the edge that enters ISSUE, so it already
    // holds READ_LAT-1 during ISSUE and keeps counting through WAIT. When it
    // reads zero the bus has been driven for READ_LAT cycles and the capture
    // happens on that edge; READ_LAT=1 therefore captures straight out of
    // ISSUE and never visits WAIT.
    assign w_ctr_load = (r_state == c_ST_TURN) ||
                        (w_rd_fire && !w_last_word && bus_gnt);
    assign w_ctr_dec  = (r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT);

    sprite_bus_wait_ctr #(
        .WIDTH      (c_WAIT_CTR_W)
    ) u_wait_ctr (
        .clk        (clock),
        .rst        (reset),
        .i_load     (w_ctr_load),
        .i_load_val (c_LAT_LOAD),
        .i_dec      (w_ctr_dec),
        .o_zero     (w_ctr_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // A zero-length request is acknowledged and dropped.
                    if (req_valid && (req_len != '0)) begin
                        r_addr  <= req_addr;
                        r_len   <= req_len;
                        r_state <= c_ST_ARB;
                    end
                end
                c_ST_ARB: begin
                    if (bus_gnt) begin
                        r_state <= c_ST_TURN;
                    end
                end
                c_ST_TURN: begin
                    r_state <= c_ST_ISSUE;
                end
                c_ST_ISSUE, c_ST_WAIT: begin
                    // Grant loss is ignored here: the word in flight always
                    // completes and the grant is re-examined in HOLD.
                    if (w_ctr_zero) begin
                        r_data  <= mem_data;
                        r_state <= c_ST_HOLD;
                    end else begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_HOLD: begin
                    if (rd_ready) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_len  <= r_len - LEN_W'(1);
                        if (w_last_word) begin
                            r_state <= c_ST_IDLE;
                        end else if (bus_gnt) begin
                            r_state <= c_ST_ISSUE;
                        end else begin
                            r_state <= c_ST_ARB;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are a pure decode of the state register, so an asynchronous
    // reset releases the bus immediately.
    assign req_ready = (r_state == c_ST_IDLE);
    assign busy      = (r_state != c_ST_IDLE);
    assign bus_req   = (r_state != c_ST_IDLE);
    assign mem_oe    = (r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT);
    assign rd_valid  = (r_state == c_ST_HOLD);
    assign rd_last   = (r_state == c_ST_HOLD) && w_last_word;
    assign mem_addr  = r_addr;
    assign rd_data   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_sprite_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_bus_reader
// Description : Self-checking bench for sprite_bus_reader. A behavioural
//               sprite memory drives mem_data only after mem_oe has been
//               high for READ_LAT cycles; expected words are queued when a
//               request is issued and popped on each read handshake.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_bus_reader;

    localparam int unsigned c_DATA_W   = 16;
    localparam int unsigned c_ADDR_W   = 12;
    localparam int unsigned c_LEN_W    = 6;
    localparam int unsigned c_READ_LAT = 2;
    localparam logic [15:0] c_BUS_JUNK = 16'hBAD0;

    logic                clock = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [c_ADDR_W-1:0] req_addr;
    logic [c_LEN_W-1:0]  req_len;
    logic                bus_req;
    logic                bus_gnt;
    logic [c_ADDR_W-1:0] mem_addr;
    logic                mem_oe;
    logic [c_DATA_W-1:0] mem_data = c_BUS_JUNK;
    logic                rd_valid;
    logic                rd_ready;
    logic [c_DATA_W-1:0] rd_data;
    logic                rd_last;
    logic                busy;

    typedef struct {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
        logic                last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   oe_cycles = 0;

    sprite_bus_reader #(
        .DATA_W   (c_DATA_W),
        .ADDR_W   (c_ADDR_W),
        .LEN_W    (c_LEN_W),
        .READ_LAT (c_READ_LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .mem_addr  (mem_addr),
        .mem_oe    (mem_oe),
        .mem_data  (mem_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [c_DATA_W-1:0] word_of(input logic [c_ADDR_W-1:0] a);
        return {a[3:0], a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Sprite memory: the bus only carries real data once mem_oe has been
    // high for READ_LAT consecutive cycles.
    always @(negedge clock) begin
        if (mem_oe) oe_cycles++;
        else        oe_cycles = 0;
        mem_data = (oe_cycles >= int'(c_READ_LAT)) ? word_of(mem_addr) : c_BUS_JUNK;
    end

    // Scoreboard and bus invariants.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_oe)   check_eq("oe_without_req", bus_req, 1);
            if (rd_valid) check_eq("oe_in_hold", mem_oe, 0);
            if (rd_valid && rd_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("extra_word", 32'(sb_q.size()), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("rd_data", rd_data, e.data);
                    check_eq("rd_last", rd_last, e.last);
                    check_eq("mem_addr", mem_addr, e.addr);
                end
            end
        end
    end

    function automatic logic cond(input int sel);
        case (sel)
            0:       return rd_valid;
            1:       return mem_oe;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input string tag);
        int n = 0;
        while (!cond(sel) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!cond(sel)) check_eq(tag, 0, 1);
    endtask

    task automatic do_req(input logic [c_ADDR_W-1:0] a, input logic [c_LEN_W-1:0] len);
        wait_cond(2, "idle_timeout");
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = len;
        for (int i = 0; i < int'(len); i++) begin
            exp_t e;
            e.addr = a + c_ADDR_W'(i);
            e.data = word_of(e.addr);
            e.last = (i == int'(len) - 1);
            sb_q.push_back(e);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n;
        logic [c_DATA_W-1:0] held;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        bus_gnt   = 1'b1;
        rd_ready  = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_bus_req", bus_req, 0);
        check_eq("rst_mem_oe", mem_oe, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_last", rd_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic burst: accept cycle + ARB + TURN + 3 x (ISSUE, WAIT, HOLD).
        do_req(12'h010, 6'd3);
        check_eq("busy_holds_off_req", req_ready, 0);
        n = 1;
        while (busy && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("burst_cycles", n, 12);
        check_eq("burst_drain", sb_q.size(), 0);

        // Address wrap.
        do_req(12'hFFE, 6'd4);
        wait_cond(2, "wrap_timeout");
        check_eq("wrap_drain", sb_q.size(), 0);

        // Consumer stall on the second word.
        do_req(12'h040, 6'd3);
        wait_cond(0, "stall_w1_timeout");
        @(posedge clock); #1;
        rd_ready = 1'b0;
        wait_cond(0, "stall_w2_timeout");
        held = rd_data;
        check_eq("stall_first", held, word_of(12'h041));
        repeat (5) begin
            @(posedge clock); #1;
            check_eq("stall_valid", rd_valid, 1);
            check_eq("stall_data", rd_data, held);
            check_eq("stall_oe", mem_oe, 0);
        end
        rd_ready = 1'b1;
        wait_cond(2, "stall_end_timeout");
        check_eq("stall_drain", sb_q.size(), 0);

        // Grant removed while word 1 is in WAIT.
        do_req(12'h080, 6'd2);
        wait_cond(1, "gnt_issue_timeout");
        @(posedge clock); #1;
        check_eq("gnt_wait_oe", mem_oe, 1);
        bus_gnt = 1'b0;
        wait_cond(0, "gnt_w1_timeout");
        @(posedge clock); #1;
        repeat (3) begin
            check_eq("arb_bus_req", bus_req, 1);
            check_eq("arb_oe", mem_oe, 0);
            @(posedge clock); #1;
        end
        bus_gnt = 1'b1;
        @(posedge clock); #1;
        check_eq("turn_oe", mem_oe, 0);
        check_eq("turn_bus_req", bus_req, 1);
        @(posedge clock); #1;
        check_eq("issue_after_turn", mem_oe, 1);
        wait_cond(2, "gnt_end_timeout");
        check_eq("gnt_drain", sb_q.size(), 0);

        // Asynchronous reset while in WAIT.
        do_req(12'h100, 6'd3);
        wait_cond(1, "rst_issue_timeout");
        @(posedge clock); #1;
        check_eq("rst_wait_oe", mem_oe, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_oe", mem_oe, 0);
        check_eq("async_rst_bus_req", bus_req, 0);
        sb_q.delete();
        #3 reset = 1'b0;
        @(posedge clock); #1;
        check_eq("post_rst_ready", req_ready, 1);
        check_eq("post_rst_busy", busy, 0);
        do_req(12'h123, 6'd2);
        wait_cond(2, "post_rst_timeout");
        check_eq("post_rst_drain", sb_q.size(), 0);

        // Zero-length request.
        do_req(12'h300, 6'd0);
        check_eq("len0_busy", busy, 0);
        repeat (4) begin
            check_eq("len0_bus_req", bus_req, 0);
            check_eq("len0_rd_valid", rd_valid, 0);
            @(posedge clock); #1;
        end

        check_eq("final_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
